// File: rtl/core_pipe_pkg.sv
// Shared field layouts and widths for the inter-stage registers of the 5-stage RISC-V core.
package core_pipe_pkg;

  localparam int ID_DATA_W  = 96;
  localparam int EX_CTRL_W  = 10;
  localparam int EX_DATA_W  = 175;
  localparam int MEM_CTRL_W = 4;
  localparam int MEM_DATA_W = 101;
  localparam int WB_CTRL_W  = 3;
  localparam int WB_DATA_W  = 101;

  // IF/ID carries no control; the decoder produces it downstream.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } id_data_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] ext_imm;
    logic [31:0] pc_plus4;
  } ex_data_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } mem_data_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } wb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } wb_data_t;

  // A bubble is all-zero control: no register write, no memory write, no jump or branch.
  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/pipe_skid_entry.sv
// One holding entry of a pipeline stage: valid flag plus control and data payload.
module pipe_skid_entry #(
  parameter int CTRL_W   = 10,
  parameter int DATA_W   = 175,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_q
);

  // Control is zeroed whenever the entry empties so a stale entry can never act as an instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else if (clr) begin
      valid  <= 1'b0;
      ctrl_q <= '0;
      if (CLR_DATA) data_q <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end else if (drop) begin
      valid  <= 1'b0;
      ctrl_q <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline register with optional 2-entry skid buffer,
// synchronous flush and a saturating bubble counter.
module pipe_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int CTRL_W   = EX_CTRL_W,
  parameter int DATA_W   = EX_DATA_W,
  parameter int SKID     = 1,
  parameter bit CLR_DATA = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              in_xfer;
  logic              out_xfer;
  logic              main_v;
  logic              main_load;
  logic              main_drop;
  logic              from_skid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;
  logic              skid_v;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Flush masks both handshakes so nothing moves in a flush cycle.
  assign in_xfer  = in_valid & in_ready & ~CLR;
  assign out_xfer = main_v & out_ready & ~CLR;

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;

      // in_ready comes straight from a flop, breaking the backward ready path.
      assign in_ready  = ~skid_v;
      assign from_skid = skid_v & out_xfer;
      assign main_load = from_skid | (in_xfer & (~main_v | out_xfer));
      assign main_drop = out_xfer;
      assign skid_load = in_xfer & main_v & ~out_xfer;

      pipe_skid_entry #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR_DATA)
      ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (CLR),
        .load   (skid_load),
        .drop   (from_skid),
        .ctrl_d (in_ctrl),
        .data_d (in_data),
        .valid  (skid_v),
        .ctrl_q (skid_ctrl),
        .data_q (skid_data)
      );
    end else begin : g_flow
      assign in_ready  = ~main_v | out_ready;
      assign from_skid = 1'b0;
      assign main_load = in_xfer;
      assign main_drop = out_xfer;
      assign skid_v    = 1'b0;
      assign skid_ctrl = '0;
      assign skid_data = '0;
    end
  endgenerate

  assign main_ctrl_d = from_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = from_skid ? skid_data : in_data;

  // Load wins over drop inside the entry, which gives pass-through on simultaneous in/out.
  pipe_skid_entry #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CLR_DATA (CLR_DATA)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (CLR),
    .load   (main_load),
    .drop   (main_drop),
    .ctrl_d (main_ctrl_d),
    .data_d (main_data_d),
    .valid  (main_v),
    .ctrl_q (main_ctrl),
    .data_q (main_data)
  );

  assign out_valid = main_v;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (~main_v & out_ready & ~CLR & (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a skid-buffered stage (u_a, 4-bit counter) and a flow-through stage (u_b).
module tb_pipe_stage_reg;

  localparam int CW = 10;
  localparam int DW = 175;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic [3:0]    a_cnt;

  logic          b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;
  logic [15:0]   b_cnt;

  int checks = 0;
  int errors = 0;
  int a_pops = 0;
  int b_pops = 0;
  logic [CW+DW-1:0] a_q[$];
  logic [CW+DW-1:0] b_q[$];
  logic [CW+DW-1:0] a_exp, b_exp;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(1'b0), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .CLR(a_clr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ), .bubble_cnt(a_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLR_DATA(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .CLR(b_clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ), .bubble_cnt(b_cnt)
  );

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop/compare on output transfers, push bench stimulus on accepted inputs.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      a_q.delete();
    end else begin
      if (a_out_valid && a_out_ready && !a_clr) begin
        if (a_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected: got ctrl %0h data %0h, expected no transfer", a_out_ctrl, a_out_data);
        end else begin
          a_exp = a_q.pop_front();
          chk("a_out_ctrl", a_out_ctrl, a_exp[CW+DW-1:DW]);
          chk("a_out_data", a_out_data, a_exp[DW-1:0]);
          a_pops++;
        end
      end
      if (!a_out_valid) chk("a_bubble_ctrl", a_out_ctrl, 0);
      if (a_clr) a_q.delete();
      else if (a_in_valid && a_in_ready) a_q.push_back({a_in_ctrl, a_in_data});
    end
  end

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      b_q.delete();
    end else begin
      if (b_out_valid && b_out_ready && !b_clr) begin
        if (b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected: got ctrl %0h data %0h, expected no transfer", b_out_ctrl, b_out_data);
        end else begin
          b_exp = b_q.pop_front();
          chk("b_out_ctrl", b_out_ctrl, b_exp[CW+DW-1:DW]);
          chk("b_out_data", b_out_data, b_exp[DW-1:0]);
          b_pops++;
        end
      end
      if (!b_out_valid) chk("b_bubble_ctrl", b_out_ctrl, 0);
      if (b_clr) b_q.delete();
      else if (b_in_valid && b_in_ready) b_q.push_back({b_in_ctrl, b_in_data});
    end
  end

  initial begin
    rst_n = 1'b0;
    a_clr = 1'b0; a_in_valid = 1'b0; a_in_ctrl = '0; a_in_data = '0; a_out_ready = 1'b0;
    b_clr = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b0;
    #1;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_ctrl", a_out_ctrl, 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_valid", b_out_valid, 0);
    repeat (2) step;
    rst_n = 1'b1;

    // Reset asserted mid-cycle while holding a transfer
    a_in_valid = 1'b1; a_in_ctrl = 10'h155; a_in_data = DW'(32'h77);
    step;
    a_in_valid = 1'b0;
    chk("a_loaded_valid", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("a_midrst_valid", a_out_valid, 0);
    chk("a_midrst_ctrl", a_out_ctrl, 0);
    chk("a_midrst_data", a_out_data, 0);
    chk("a_midrst_occ", a_occ, 0);
    chk("a_midrst_in_ready", a_in_ready, 1);
    step;
    rst_n = 1'b1;

    // Bubble counter: saturates at 15, flush cycle does not count
    a_out_ready = 1'b1;
    repeat (5) step;
    chk("a_cnt_5", a_cnt, 5);
    a_clr = 1'b1;
    step;
    a_clr = 1'b0;
    chk("a_cnt_clr", a_cnt, 5);
    repeat (15) step;
    chk("a_cnt_sat", a_cnt, 15);

    // Streaming 0xA..0xD with out_ready high
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_ctrl  = CW'(32'h0A0 + i);
      a_in_data  = DW'(32'hA + i);
      step;
      chk("a_stream_occ", a_occ, 1);
    end
    a_in_valid = 1'b0;
    step;
    chk("a_stream_drained", a_occ, 0);

    // Backpressure fills the skid entry
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 10'h101; a_in_data = DW'(32'h1);
    step;
    a_in_ctrl = 10'h102; a_in_data = DW'(32'h2);
    step;
    a_in_valid = 1'b0;
    chk("a_bp_occ2", a_occ, 2);
    chk("a_bp_in_ready", a_in_ready, 0);
    chk("a_bp_hold", a_out_data, 1);
    a_out_ready = 1'b1;
    step;
    chk("a_bp_occ1", a_occ, 1);
    chk("a_bp_ready_back", a_in_ready, 1);
    chk("a_bp_second", a_out_data, 2);
    step;
    chk("a_bp_occ0", a_occ, 0);

    // Flush a full stage while a new item is offered
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 10'h3FF; a_in_data = DW'(32'h3);
    step;
    a_in_data = DW'(32'h4);
    step;
    chk("a_fl_occ2", a_occ, 2);
    chk("a_fl_ctrl_full", a_out_ctrl, 10'h3FF);
    a_clr = 1'b1; a_in_data = DW'(32'h5);
    step;
    chk("a_fl_valid", a_out_valid, 0);
    chk("a_fl_ctrl", a_out_ctrl, 0);
    chk("a_fl_occ", a_occ, 0);
    chk("a_fl_in_ready", a_in_ready, 1);
    step;
    chk("a_fl_hold_occ", a_occ, 0);
    a_clr = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (3) step;
    chk("a_fl_stays_empty", a_out_valid, 0);
    a_in_valid = 1'b1; a_in_ctrl = 10'h006; a_in_data = DW'(32'h6);
    step;
    a_in_valid = 1'b0;
    step;
    chk("a_pops", a_pops, 7);
    chk("a_q_empty", a_q.size(), 0);

    // Flow-through stage stall
    b_in_valid = 1'b1; b_in_ctrl = 10'h011; b_in_data = DW'(32'h11);
    step;
    b_in_ctrl = 10'h022; b_in_data = DW'(32'h22);
    #1;
    chk("b_stall_ready", b_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("b_hold_data", b_out_data, 32'h11);
      chk("b_hold_ready", b_in_ready, 0);
    end
    b_out_ready = 1'b1;
    #1;
    chk("b_release_ready", b_in_ready, 1);
    step;
    b_in_valid = 1'b0;
    chk("b_next_data", b_out_data, 32'h22);
    chk("b_next_valid", b_out_valid, 1);
    step;
    chk("b_drain_valid", b_out_valid, 0);
    chk("b_drain_ctrl", b_out_ctrl, 0);
    chk("b_cnt_0", b_cnt, 0);
    step;
    chk("b_cnt_1", b_cnt, 1);
    chk("b_pops", b_pops, 2);
    chk("b_q_empty", b_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage RISC-V core. Replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field with a valid/ready handshake, so stalls propagate backward and are not ad-hoc enables.
- Supports a synchronous flush that inserts a bubble, an optional 2-entry skid buffer that breaks the ready timing path, and a saturating bubble counter for performance monitoring.

Parameters:
- CTRL_W, 10, width of the control field (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc packed).
- DATA_W, 175, width of the data field (RD1, RD2, PC, Rs1, Rs2, Rd, ExtImm, PCPlus4 packed).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CLR_DATA, 0, 1 = flush/reset also zeroes the data field; 0 = flush zeroes only the control field and valid.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- CLR  input  1  synchronous flush, takes effect at the next rising edge.
- in_valid  input  1  upstream has a transfer.
- in_ready  output  1  stage can accept a transfer.
- in_ctrl  input  CTRL_W  upstream control field.
- in_data  input  DATA_W  upstream data field.
- out_valid  output  1  stage holds a valid transfer.
- out_ready  input  1  downstream accepts.
- out_ctrl  output  CTRL_W  registered control; all zero whenever out_valid=0.
- out_data  output  DATA_W  registered data.
- occupancy  output  2  entries held (0..2; max 1 when SKID=0).
- bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0 and out_ready=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, bubble_cnt=0.
  - in_ready=1 while in reset and immediately after.
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Latency is 1 cycle, input edge to out_valid.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - On an input transfer, load the main entry.
  - On an output transfer with no input transfer, out_valid←0 and out_ctrl←0.
- SKID=1:
  - Entries: main (drives the outputs) and skid. in_ready = ~skid_valid, registered.
  - Input transfer while the main entry is empty or draining goes to main.
  - Input transfer while main is full and out_ready=0 goes to skid; in_ready drops next cycle.
  - Output transfer with skid full: main←skid, skid empties, in_ready rises next cycle.
  - Order is strictly FIFO. No transfer is dropped or duplicated.
- Occupancy transitions (SKID=1):
  - 0→1 on an input transfer.
  - 1→1 on simultaneous input and output transfers.
  - 1→2 on an input transfer with out_ready=0.
  - 2→1 on an output transfer (no input possible, in_ready=0).
  - 1→0 on an output transfer only.
- CLR:
  - Overrides every load and handshake in the same cycle.
  - Next cycle: all entries invalid, occupancy=0, out_ctrl=0, out_data=0 only if CLR_DATA=1, in_ready=1.
  - A concurrent in_valid is discarded.
  - Holding CLR high keeps the stage empty.
- Control-field rule: out_ctrl is forced to 0 whenever the stage is empty, so a bubble never writes a register or memory.
- bubble_cnt:
  - Increments when out_valid=0 & out_ready=1 & CLR=0.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- rst_n asserted mid-transfer: entries are lost and no output transfer occurs.
- in_valid must hold stable until accepted (upstream obligation). The stage does not check this.

Decomposition:
- Shared package core_pipe_pkg holds:
  - per-stage CTRL_W/DATA_W localparams;
  - packed struct typedefs ex_ctrl_t and ex_data_t for ID/EX (and the equivalents for the other stages);
  - a bubble constant of all-zero ctrl.
- One natural sub-module: pipe_skid_entry, a single valid+payload holding register with load/clear, instantiated twice when SKID=1.

Test Plan:
- Reset: rst_n=0 mid-cycle with out_valid=1 → outputs 0 immediately; in_ready=1; bubble_cnt=0.
- Stream, SKID=1: in_valid=1 for 4 cycles with data 0xA..0xD, out_ready=1 → out_data 0xA..0xD on consecutive cycles, one cycle later; occupancy stays 1.
- Backpressure, SKID=1:
  - out_ready=0 while sending 0x1 then 0x2 → occupancy=2, in_ready=0, out_data holds 0x1.
  - Then out_ready=1 → 0x1, then 0x2 out; in_ready=1 after the first drain.
- Flush: occupancy=2 with ctrl=0x3FF, assert CLR with in_valid=1 data 0x5 → next cycle out_valid=0, out_ctrl=0, occupancy=0, 0x5 never appears.
- SKID=0 stall: out_ready=0, out_valid=1 → in_ready=0 combinationally; out_data held for 3 cycles; release → next item passes.
- Counter: CNT_W=4, out_valid=0, out_ready=1 for 20 cycles → bubble_cnt=15 (saturated); a CLR cycle does not increment.
